// File: rtl/adder_arb_pkg.sv
// Shared definitions for the two-port add/sub arbiter: slot states, port indices
// and data width.
package adder_arb_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/adder_arb_adder32.sv
// Adder_32: combinational 32-bit add/subtract unit with two's-complement
// signed-overflow detection.
module Adder_32
    import adder_arb_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_overflow
);

    logic [DATA_W-1:0] w_b_eff;

    // Subtraction is a + ~b + 1, so overflow uses the effective (inverted) operand.
    always_comb begin
        w_b_eff    = i_sub ? ~i_b : i_b;
        o_sum      = i_a + w_b_eff + {{(DATA_W-1){1'b0}}, i_sub};
        o_overflow = (i_a[DATA_W-1] == w_b_eff[DATA_W-1]) &&
                     (o_sum[DATA_W-1] != i_a[DATA_W-1]);
    end

endmodule

// File: rtl/adder_arb.sv
// adder_arb: two requesters share one Adder_32 through a round-robin grant and a
// single result slot. Define ADDER_ARB_STATS_EN to add saturating per-port grant counters.
module adder_arb
    import adder_arb_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FIRST_PORT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_overflow,
    output logic              rsp_zeroflag
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    slot_state_t       r_state;
    slot_state_t       w_state_nxt;
    logic              r_owner;
    logic              r_prio;
    logic              r_run;
    logic [DATA_W-1:0] r_sum;
    logic              r_ovf;
    logic              r_zf;

    logic              w_grant;
    logic              w_drain;
    logic              w_free;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_acc;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_sub;
    logic [DATA_W-1:0] w_sum;
    logic              w_ovf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SLOT_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_acc) w_state_nxt = SLOT_FULL;
            SLOT_FULL: begin
                if (w_acc)        w_state_nxt = SLOT_FULL;
                else if (w_drain) w_state_nxt = SLOT_EMPTY;
            end
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        rsp0_valid   = (r_state == SLOT_FULL) && (r_owner == PORT0);
        rsp1_valid   = (r_state == SLOT_FULL) && (r_owner == PORT1);
        rsp_sum      = r_sum;
        rsp_overflow = r_ovf;
        rsp_zeroflag = r_zf;
    end

    // Grant goes to a lone requester, otherwise to the port favoured by r_prio.
    always_comb begin
        if (req0_valid && !req1_valid)      w_grant = PORT0;
        else if (req1_valid && !req0_valid) w_grant = PORT1;
        else                                w_grant = r_prio;

        w_drain    = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
        w_free     = (r_state == SLOT_EMPTY) || w_drain;
        req0_ready = r_run && w_free && req0_valid && (w_grant == PORT0);
        req1_ready = r_run && w_free && req1_valid && (w_grant == PORT1);
        w_acc0     = req0_valid && req0_ready;
        w_acc1     = req1_valid && req1_ready;
        w_acc      = w_acc0 || w_acc1;

        w_a   = (w_grant == PORT1) ? req1_a   : req0_a;
        w_b   = (w_grant == PORT1) ? req1_b   : req0_b;
        w_sub = (w_grant == PORT1) ? req1_sub : req0_sub;
    end

    Adder_32 u_adder (
        .i_a        (w_a),
        .i_b        (w_b),
        .i_sub      (w_sub),
        .o_sum      (w_sum),
        .o_overflow (w_ovf)
    );

    // r_run keeps ready low while reset is asserted without using rst_n as data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_owner <= PORT0;
            r_prio  <= (FIRST_PORT != 0);
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_zf    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_acc) begin
                r_owner <= w_grant;
                r_prio  <= ~w_grant;
                r_sum   <= w_sum;
                r_ovf   <= w_ovf;
                r_zf    <= (w_sum == '0);
            end
        end
    end

`ifdef ADDER_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_acc0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_acc1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_adder_arb.sv
// Directed bench for adder_arb: vector table for add/sub results plus sequences
// for round-robin, back-pressure, mid-operation reset and (optionally) grant counters.
module tb_adder_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_sum;
    logic        rsp_overflow, rsp_zeroflag;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

`ifdef ADDER_ARB_STATS_EN
    logic [3:0] grant_cnt0, grant_cnt1;
    adder_arb #(.CNT_W(4), .FIRST_PORT(0)) dut (
`else
    adder_arb #(.CNT_W(16), .FIRST_PORT(0)) dut (
`endif
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow), .rsp_zeroflag(rsp_zeroflag)
`ifdef ADDER_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_ovf;
        logic        exp_zf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Polls for the given port's ready, up to a fixed number of cycles.
    task automatic wait_ready(input logic port, input string name);
        int n = 0;
        #1;
        while (!(port ? req1_ready : req0_ready) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {31'b0, (port ? req1_ready : req0_ready)}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd5,         32'd3,         1'b0, 32'd8,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'd7,         32'd7,         1'b1, 32'd0,         1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'h7FFFFFFF,  32'd1,         1'b0, 32'h80000000,  1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h80000000,  32'd1,         1'b1, 32'h7FFFFFFF,  1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFFFFFF,  32'd1,         1'b0, 32'd0,         1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'd0,         32'd1,         1'b1, 32'hFFFFFFFF,  1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h80000000,  32'h80000000,  1'b0, 32'd0,         1'b1, 1'b1};
        vecs[7] = '{1'b1, 32'd0,         32'h80000000,  1'b1, 32'h80000000,  1'b1, 1'b0};

        // Reset state, with requests already valid
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd1; req0_b = 32'd1; req0_sub = 1'b0;
        req1_a = 32'd1; req1_b = 32'd1; req1_sub = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req0_ready", {31'b0, req0_ready}, 32'd0);
        chk("reset_req1_ready", {31'b0, req1_ready}, 32'd0);
        chk("reset_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("reset_sum",        rsp_sum,             32'd0);
        chk("reset_flags",      {30'b0, rsp_overflow, rsp_zeroflag}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 rst_n = 1'b1;

        // Vector table, one isolated transfer each
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (vecs[i].port) begin
                req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_sub = vecs[i].sub;
            end else begin
                req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_sub = vecs[i].sub;
            end
            wait_ready(vecs[i].port, $sformatf("v%0d_ready", i));
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk($sformatf("v%0d_rsp_valid", i),
                {30'b0, rsp1_valid, rsp0_valid}, vecs[i].port ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_sum", i), rsp_sum, vecs[i].exp_sum);
            chk($sformatf("v%0d_ovf", i), {31'b0, rsp_overflow}, {31'b0, vecs[i].exp_ovf});
            chk($sformatf("v%0d_zf", i),  {31'b0, rsp_zeroflag}, {31'b0, vecs[i].exp_zf});
        end

        // Round-robin under continuous contention, one response per cycle
        @(posedge clk); #1;
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd0; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd0; req1_sub = 1'b0;
        wait_ready(1'b0, "rr_first_ready");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr%0d_grant", i), {30'b0, req1_ready, req0_ready},
                (i % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk); #1;
            chk($sformatf("rr%0d_rsp_valid", i), {30'b0, rsp1_valid, rsp0_valid},
                (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_sum", i), rsp_sum, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Back-pressure on port 0 while both ports keep requesting
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_sub = 1'b0;
        wait_ready(1'b0, "bp_accept_ready");
        @(posedge clk); #1;
        req0_a = 32'd100; req0_b = 32'd1;
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd5; req1_sub = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_rsp0_valid", i), {31'b0, rsp0_valid}, 32'd1);
            chk($sformatf("bp%0d_sum", i), rsp_sum, 32'd30);
            chk($sformatf("bp%0d_readies", i), {30'b0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        #1;
        chk("bp_release_grant", {30'b0, req1_ready, req0_ready}, 32'd2);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("bp_after_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd2);
        chk("bp_after_sum", rsp_sum, 32'd10);
        @(posedge clk); #1;

        // Reset with the slot full: the held result must never appear
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_sub = 1'b0;
        wait_ready(1'b0, "mid_reset_ready");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("mid_reset_full", {31'b0, rsp0_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #2;
        chk("mid_reset_cleared", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_reset%0d_no_rsp", i), {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        end

`ifdef ADDER_ARB_STATS_EN
        // Saturating grant counter with CNT_W=4
        begin
            int acc = 0;
            int cyc = 0;
            do_reset();
            req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_sub = 1'b0;
            #1;
            while (acc < 20 && cyc < 100) begin
                if (req0_ready) acc++;
                @(posedge clk); #1;
                cyc++;
            end
            req0_valid = 1'b0;
            chk("stats_accepts", acc, 32'd20);
            chk("stats_cnt0", {28'b0, grant_cnt0}, 32'd15);
            chk("stats_cnt1", {28'b0, grant_cnt1}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Mutual exclusion of response valids, checked on every falling edge
    always @(negedge clk) begin
        if (rsp0_valid && rsp1_valid) begin
            n_miss++;
            $display("FAIL rsp_exclusive: got both valid expected at most one");
        end
    end

endmodule
